// File: rtl/glb_ld_dma_sched_pkg.sv
// Shared global-buffer constants and types for the load-DMA header scheduler.
package global_buffer_param;
  localparam int QUEUE_DEPTH   = 4;
  localparam int TIMEOUT_WIDTH = 16;
endpackage

package global_buffer_pkg;
  typedef enum logic [1:0] {
    LD_DMA_OFF    = 2'd0,
    LD_DMA_NORMAL = 2'd1,
    LD_DMA_REPEAT = 2'd2
  } ld_dma_mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } sched_state_e;
endpackage

// File: rtl/glb_ld_dma_sched_if.sv
// Scheduler <-> load-DMA engine handshake: issue strobe + slot index, done strobe back.
interface glb_ld_dma_sched_if #(
  parameter int QIDX_WIDTH = $clog2(global_buffer_param::QUEUE_DEPTH)
);
  logic                  dma_start_pulse;
  logic [QIDX_WIDTH-1:0] dma_q_idx;
  logic                  dma_done_pulse;

  modport master (output dma_start_pulse, output dma_q_idx, input dma_done_pulse);
  modport slave  (input dma_start_pulse, input dma_q_idx, output dma_done_pulse);
endinterface

// File: rtl/glb_prio_find_next.sv
// Lowest set bit of vec at or above base; base may be QUEUE_DEPTH (nothing found).
module glb_prio_find_next #(
  parameter int QUEUE_DEPTH = 4,
  parameter int QIDX_WIDTH  = $clog2(QUEUE_DEPTH)
) (
  input  logic [QUEUE_DEPTH-1:0] vec,
  input  logic [QIDX_WIDTH:0]    base,
  output logic                   found,
  output logic [QIDX_WIDTH-1:0]  idx
);
  logic [QIDX_WIDTH:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    // Scan high to low so the lowest qualifying index is the last one written.
    for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
      pos = (QIDX_WIDTH + 1)'(i);
      if (vec[i] && (pos >= base)) begin
        found = 1'b1;
        idx   = pos[QIDX_WIDTH-1:0];
      end
    end
  end
endmodule

// File: rtl/glb_ld_dma_sched.sv
// Load-DMA header queue sequencer for one GLB tile.
// Optional watchdog enabled by defining GLB_LD_DMA_SCHED_TIMEOUT_EN.
module glb_ld_dma_sched
  import global_buffer_pkg::*;
#(
  parameter int QUEUE_DEPTH = global_buffer_param::QUEUE_DEPTH,
  parameter int QIDX_WIDTH  = $clog2(QUEUE_DEPTH)
`ifdef GLB_LD_DMA_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_WIDTH = global_buffer_param::TIMEOUT_WIDTH
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic                     cgra_soft_reset,
  input  logic [1:0]               cfg_ld_dma_mode,
  input  logic [QUEUE_DEPTH-1:0]   cfg_hdr_valid,
  input  logic                     strm_start_pulse,
  glb_ld_dma_sched_if.master       dma,
  output logic [QUEUE_DEPTH-1:0]   cfg_invalidate_pulse,
  output logic                     strm_g2f_interrupt_pulse,
  output logic                     busy
`ifdef GLB_LD_DMA_SCHED_TIMEOUT_EN
  , input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  output logic                     timeout_err_pulse
`endif
);
  sched_state_e            state, state_n;
  logic [QIDX_WIDTH-1:0]   idx, idx_n;
  logic                    start_n, irq_n;
  logic [QUEUE_DEPTH-1:0]  inv_n;
  logic                    first_found, next_found;
  logic [QIDX_WIDTH-1:0]   first_idx, next_idx;
  logic                    mode_on, mode_normal, mode_repeat;
`ifdef GLB_LD_DMA_SCHED_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] cnt, cnt_n;
  logic                     tmo_n;
`endif

  assign mode_normal = (cfg_ld_dma_mode == LD_DMA_NORMAL);
  assign mode_repeat = (cfg_ld_dma_mode == LD_DMA_REPEAT);
  assign mode_on     = mode_normal | mode_repeat;

  glb_prio_find_next #(.QUEUE_DEPTH(QUEUE_DEPTH), .QIDX_WIDTH(QIDX_WIDTH)) u_first (
    .vec(cfg_hdr_valid), .base('0), .found(first_found), .idx(first_idx)
  );

  glb_prio_find_next #(.QUEUE_DEPTH(QUEUE_DEPTH), .QIDX_WIDTH(QIDX_WIDTH)) u_next (
    .vec(cfg_hdr_valid), .base((QIDX_WIDTH + 1)'(idx) + (QIDX_WIDTH + 1)'(1)),
    .found(next_found), .idx(next_idx)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    start_n = 1'b0;
    irq_n   = 1'b0;
    inv_n   = '0;
`ifdef GLB_LD_DMA_SCHED_TIMEOUT_EN
    cnt_n   = cnt;
    tmo_n   = 1'b0;
`endif
    if (clk_en) begin
      if (cgra_soft_reset) begin
        state_n = S_IDLE;
      end else if (state == S_IDLE) begin
        if (strm_start_pulse && mode_on) begin
          if (first_found) begin
            idx_n   = first_idx;
            start_n = 1'b1;
            state_n = S_WAIT;
          end else begin
            irq_n = 1'b1;
          end
        end
      end else begin
`ifdef GLB_LD_DMA_SCHED_TIMEOUT_EN
        cnt_n = cnt + 1'b1;
`endif
        if (dma.dma_done_pulse) begin
          if (mode_normal) inv_n = {{(QUEUE_DEPTH-1){1'b0}}, 1'b1} << idx;
          if (next_found) begin
            idx_n   = next_idx;
            start_n = 1'b1;
          end else if (mode_repeat && first_found) begin
            idx_n   = first_idx;
            start_n = 1'b1;
          end else begin
            irq_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
`ifdef GLB_LD_DMA_SCHED_TIMEOUT_EN
        else if ((cfg_timeout != '0) && (cnt == cfg_timeout)) begin
          tmo_n   = 1'b1;
          irq_n   = 1'b1;
          state_n = S_IDLE;
        end
`endif
      end
`ifdef GLB_LD_DMA_SCHED_TIMEOUT_EN
      if (start_n) cnt_n = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                    <= S_IDLE;
      idx                      <= '0;
      dma.dma_start_pulse      <= 1'b0;
      cfg_invalidate_pulse     <= '0;
      strm_g2f_interrupt_pulse <= 1'b0;
      busy                     <= 1'b0;
`ifdef GLB_LD_DMA_SCHED_TIMEOUT_EN
      cnt                      <= '0;
      timeout_err_pulse        <= 1'b0;
`endif
    end else begin
      state                    <= state_n;
      idx                      <= idx_n;
      dma.dma_start_pulse      <= start_n;
      cfg_invalidate_pulse     <= inv_n;
      strm_g2f_interrupt_pulse <= irq_n;
      busy                     <= (state_n == S_WAIT);
`ifdef GLB_LD_DMA_SCHED_TIMEOUT_EN
      cnt                      <= cnt_n;
      timeout_err_pulse        <= tmo_n;
`endif
    end
  end

  assign dma.dma_q_idx = idx;
endmodule

// File: tb/tb_glb_ld_dma_sched.sv
// Directed bench for glb_ld_dma_sched; expected values are hand-derived per step.
module tb_glb_ld_dma_sched;
  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  logic       cgra_soft_reset;
  logic [1:0] cfg_ld_dma_mode;
  logic [3:0] cfg_hdr_valid;
  logic       strm_start_pulse;
  logic [3:0] cfg_invalidate_pulse;
  logic       strm_g2f_interrupt_pulse;
  logic       busy;
`ifdef GLB_LD_DMA_SCHED_TIMEOUT_EN
  logic [15:0] cfg_timeout;
  logic        timeout_err_pulse;
`endif
  int checks = 0;
  int errors = 0;

  glb_ld_dma_sched_if #(.QIDX_WIDTH(2)) dma_if ();

  glb_ld_dma_sched #(.QUEUE_DEPTH(4), .QIDX_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .cgra_soft_reset(cgra_soft_reset),
    .cfg_ld_dma_mode(cfg_ld_dma_mode), .cfg_hdr_valid(cfg_hdr_valid),
    .strm_start_pulse(strm_start_pulse), .dma(dma_if),
    .cfg_invalidate_pulse(cfg_invalidate_pulse),
    .strm_g2f_interrupt_pulse(strm_g2f_interrupt_pulse), .busy(busy)
`ifdef GLB_LD_DMA_SCHED_TIMEOUT_EN
    , .cfg_timeout(cfg_timeout), .timeout_err_pulse(timeout_err_pulse)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic outs(input string tag, input logic st, input logic [1:0] qi,
                      input logic [3:0] inv, input logic irq, input logic bz);
    chk({tag, ".start"}, 32'(dma_if.dma_start_pulse), 32'(st));
    chk({tag, ".idx"},   32'(dma_if.dma_q_idx), 32'(qi));
    chk({tag, ".inv"},   32'(cfg_invalidate_pulse), 32'(inv));
    chk({tag, ".irq"},   32'(strm_g2f_interrupt_pulse), 32'(irq));
    chk({tag, ".busy"},  32'(busy), 32'(bz));
  endtask

  // Done arrives 5 cycles after the start pulse became visible.
  task automatic done_after_5();
    repeat (4) tick();
    dma_if.dma_done_pulse = 1'b1;
    tick();
    dma_if.dma_done_pulse = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1; cgra_soft_reset = 1'b0;
    cfg_ld_dma_mode = 2'd0; cfg_hdr_valid = 4'b0000; strm_start_pulse = 1'b0;
    dma_if.dma_done_pulse = 1'b0;
`ifdef GLB_LD_DMA_SCHED_TIMEOUT_EN
    cfg_timeout = 16'd0;
`endif
    #2;
    outs("reset", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
    tick(); reset = 1'b0; tick();

    // NORMAL pass over 1011: slots 0, 1, 3
    cfg_ld_dma_mode = 2'd1; cfg_hdr_valid = 4'b1011;
    strm_start_pulse = 1'b1; tick(); strm_start_pulse = 1'b0;
    outs("norm.s0", 1'b1, 2'd0, 4'b0000, 1'b0, 1'b1);
    tick();
    outs("norm.wait", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1);
    repeat (3) tick(); dma_if.dma_done_pulse = 1'b1; tick(); dma_if.dma_done_pulse = 1'b0;
    outs("norm.s1", 1'b1, 2'd1, 4'b0001, 1'b0, 1'b1);
    done_after_5();
    outs("norm.s3", 1'b1, 2'd3, 4'b0010, 1'b0, 1'b1);
    done_after_5();
    outs("norm.end", 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0);
    tick();
    outs("norm.idle", 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0);

    // REPEAT over 0101 loops 0,2,0,2,...
    cfg_ld_dma_mode = 2'd2; cfg_hdr_valid = 4'b0101;
    strm_start_pulse = 1'b1; tick(); strm_start_pulse = 1'b0;
    outs("rep.s0", 1'b1, 2'd0, 4'b0000, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      done_after_5();
      outs($sformatf("rep.d%0d", k), 1'b1, (k % 2 == 1) ? 2'd2 : 2'd0, 4'b0000, 1'b0, 1'b1);
    end
    tick();
    cgra_soft_reset = 1'b1; tick(); cgra_soft_reset = 1'b0;
    outs("rep.soft", 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0);

    // No valid headers: immediate interrupt
    cfg_ld_dma_mode = 2'd1; cfg_hdr_valid = 4'b0000;
    strm_start_pulse = 1'b1; tick(); strm_start_pulse = 1'b0;
    outs("empty", 1'b0, 2'd2, 4'b0000, 1'b1, 1'b0);
    tick();
    outs("empty.after", 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0);

    // Mode OFF and mode 3 ignore start
    cfg_hdr_valid = 4'b1111;
    cfg_ld_dma_mode = 2'd0; strm_start_pulse = 1'b1; tick(); strm_start_pulse = 1'b0;
    outs("off0", 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0);
    cfg_ld_dma_mode = 2'd3; strm_start_pulse = 1'b1; tick(); strm_start_pulse = 1'b0;
    outs("off3", 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0);

    // Start while busy ignored; done+start together drops start; done in IDLE ignored
    cfg_ld_dma_mode = 2'd1; cfg_hdr_valid = 4'b0001;
    strm_start_pulse = 1'b1; tick();
    outs("busy.s0", 1'b1, 2'd0, 4'b0000, 1'b0, 1'b1);
    tick(); strm_start_pulse = 1'b0;
    outs("busy.restart", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1);
    strm_start_pulse = 1'b1; dma_if.dma_done_pulse = 1'b1; tick();
    strm_start_pulse = 1'b0; dma_if.dma_done_pulse = 1'b0;
    outs("busy.done", 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0);
    tick();
    outs("busy.idle", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
    dma_if.dma_done_pulse = 1'b1; tick(); dma_if.dma_done_pulse = 1'b0;
    outs("idle.done", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);

    // clk_en low for 3 cycles swallows a done pulse
    cfg_hdr_valid = 4'b0011;
    strm_start_pulse = 1'b1; tick(); strm_start_pulse = 1'b0;
    outs("cke.s0", 1'b1, 2'd0, 4'b0000, 1'b0, 1'b1);
    clk_en = 1'b0; dma_if.dma_done_pulse = 1'b1; tick(); dma_if.dma_done_pulse = 1'b0;
    outs("cke.f1", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1);
    tick();
    outs("cke.f2", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1);
    tick(); clk_en = 1'b1;
    outs("cke.f3", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1);
    tick();
    outs("cke.lost", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1);
    dma_if.dma_done_pulse = 1'b1; tick(); dma_if.dma_done_pulse = 1'b0;
    outs("cke.s1", 1'b1, 2'd1, 4'b0001, 1'b0, 1'b1);

    // Asynchronous reset mid-WAIT clears outputs without a clock edge
    #2 reset = 1'b1;
    #1 outs("areset", 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
    tick(); reset = 1'b0; tick();

`ifdef GLB_LD_DMA_SCHED_TIMEOUT_EN
    cfg_hdr_valid = 4'b0001; cfg_timeout = 16'd8;
    strm_start_pulse = 1'b1; tick(); strm_start_pulse = 1'b0;
    chk("tmo.s0", 32'(dma_if.dma_start_pulse), 32'd1);
    repeat (8) tick();
    chk("tmo.pre", 32'(timeout_err_pulse), 32'd0);
    chk("tmo.pre.busy", 32'(busy), 32'd1);
    tick();
    chk("tmo.err", 32'(timeout_err_pulse), 32'd1);
    outs("tmo.fire", 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0);
    cfg_timeout = 16'd0;
    strm_start_pulse = 1'b1; tick(); strm_start_pulse = 1'b0;
    repeat (40) tick();
    chk("tmo.off.err", 32'(timeout_err_pulse), 32'd0);
    chk("tmo.off.busy", 32'(busy), 32'd1);
    cgra_soft_reset = 1'b1; tick(); cgra_soft_reset = 1'b0;
    chk("tmo.off.soft", 32'(busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/glb_ld_dma_sched.md
Name: glb_ld_dma_sched

Overview:
- Sequencer for one GLB tile's load-DMA header queue.
- On a stream start pulse it walks the QUEUE_DEPTH configured headers in index order and hands each valid one to the load-DMA engine with a one-cycle start pulse.
- It waits for the engine's done pulse, invalidates consumed headers, and raises the tile's g2f interrupt pulse once the pass completes.
- Sits between glb_tile_cfg (header valid bits, mode) and the load-DMA engine inside glb_core.

Parameters:
- QUEUE_DEPTH, 4, number of load-DMA header slots.
- QIDX_WIDTH, $clog2(QUEUE_DEPTH), width of the queue index.
- TIMEOUT_WIDTH, 16, watchdog counter width (used only with the optional feature).

Ports:
- clk  in  1  tile clock.
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  pipelined clock enable; all state is frozen when low.
- cgra_soft_reset  in  1  synchronous abort to IDLE.
- cfg_ld_dma_mode  in  2  0=OFF, 1=NORMAL (single pass), 2=REPEAT (loop), 3=treated as OFF.
- cfg_hdr_valid  in  QUEUE_DEPTH  per-slot header valid bit from config.
- strm_start_pulse  in  1  one-cycle trigger.
- dma_done_pulse  in  1  engine finished the current header.
- dma_start_pulse  out  1  one-cycle issue strobe to the engine.
- dma_q_idx  out  QIDX_WIDTH  header slot the engine must use; stable from start to done.
- cfg_invalidate_pulse  out  QUEUE_DEPTH  one-hot, one-cycle clear of a consumed valid bit.
- strm_g2f_interrupt_pulse  out  1  pass complete.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock. reset is asynchronous, active-high; clk is the only clock.
- Reset values: all outputs 0, state IDLE, idx 0.
- All outputs are registered.
- States: IDLE, WAIT.
- "First valid at/after n" is a priority search over cfg_hdr_valid, sampled live, lowest index wins.
- IDLE:
  - Start is accepted when strm_start_pulse=1, clk_en=1 and mode is 1 or 2.
  - Accepted start with some valid bit set: idx <= first valid; next cycle dma_start_pulse=1 and dma_q_idx=idx; go to WAIT.
  - Accepted start with no valid bit set: next cycle strm_g2f_interrupt_pulse=1; stay IDLE.
  - Start while mode is OFF: ignored.
- WAIT, on dma_done_pulse at cycle j:
  - NORMAL: cfg_invalidate_pulse[idx]=1 at j+1. REPEAT: no invalidate.
  - Next slot = first valid strictly above idx.
  - If one exists: idx <= it, dma_start_pulse=1 at j+1, stay WAIT.
  - If none, NORMAL: strm_g2f_interrupt_pulse=1 at j+1, go IDLE.
  - If none, REPEAT: wrap to the first valid from 0. If none remain at all, emit the interrupt and go IDLE.
- Ignored events:
  - strm_start_pulse while busy.
  - dma_done_pulse while in IDLE.
- Simultaneous events:
  - Done and start in the same cycle: start is dropped; done is handled as above.
  - A new start is accepted no earlier than the cycle after the interrupt.
- clk_en=0: no state change, pulses held 0, dma_q_idx held; inputs arriving that cycle are lost.
- cgra_soft_reset=1 (when clk_en=1): go to IDLE next cycle; all pulses 0; no invalidate; no interrupt. It has priority over every other event.
- Mode changes mid-pass take effect at the next done pulse.
- Reset mid-pass: immediate return to reset values; the engine is separately reset.

Optional Feature:
- Macro: GLB_LD_DMA_SCHED_TIMEOUT_EN.
- When defined, adds ports:
  - cfg_timeout  in  TIMEOUT_WIDTH
  - timeout_err_pulse  out  1
- Watchdog counter:
  - Clears on each dma_start_pulse and increments each enabled WAIT cycle.
  - When it reaches cfg_timeout (nonzero), the block emits timeout_err_pulse and strm_g2f_interrupt_pulse together next cycle, with no invalidate, and goes to IDLE.
  - cfg_timeout=0 disables the watchdog.
- When not defined: no extra ports or logic; WAIT lasts until done, soft reset or reset.

Decomposition:
- Into global_buffer_pkg:
  - ld_dma_mode_e enum (OFF/NORMAL/REPEAT).
  - sched_state_e enum.
- QUEUE_DEPTH and TIMEOUT_WIDTH come from global_buffer_param.
- One sub-module, glb_prio_find_next: combinational "first set bit at or above n" over QUEUE_DEPTH, used for both the start search and the next-slot search.

Test Plan:
- NORMAL, valid=4'b1011: start at t=10; done pulses 5 cycles after each start.
  - Required: starts at t=11 (idx0), then idx1, then idx3.
  - Required: invalidate pulses 0001, 0010, 1000.
  - Required: interrupt one cycle after the third done; busy low after that.
- REPEAT, valid=4'b0101: 5 done pulses.
  - Required: idx sequence 0, 2, 0, 2, 0; no invalidates; no interrupt.
  - Then assert soft reset: IDLE, no interrupt.
- Start with valid=0, mode=1: interrupt at t+1; no dma_start_pulse.
- Start with mode=0 or mode=3: no outputs. Second start while busy: ignored; exactly one dma_start_pulse. Done pulse in IDLE: no response.
- clk_en low for 3 cycles across a done pulse: state frozen, done lost, idx held. Async reset mid-WAIT: all outputs 0 immediately.
- With GLB_LD_DMA_SCHED_TIMEOUT_EN, cfg_timeout=8, no done pulse: timeout_err_pulse and interrupt together in the cycle after the counter reaches 8, then IDLE. With cfg_timeout=0: waits indefinitely.
